// File: rtl/dac_scan_pkg.sv
// Shared types and constants for the serial DAC scan generator.
package dac_scan_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CODE_BITS  = 12;
    localparam int unsigned SUM_BITS   = CODE_BITS + 1;
    localparam int unsigned IDX_BITS   = 4;
    localparam int unsigned DIV_BITS   = 8;

    localparam logic [1:0]           PD_NORMAL = 2'b00;
    localparam logic [CODE_BITS-1:0] CODE_MAX  = '1;
    localparam logic                 DIR_UP    = 1'b1;
    localparam logic                 DIR_DOWN  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_e;

    // 16-bit word shifted to the DAC, MSB first
    typedef struct packed {
        logic [1:0]           rsvd;
        logic [1:0]           pd;
        logic [CODE_BITS-1:0] code;
    } frame_t;

    function automatic frame_t make_frame(input logic [CODE_BITS-1:0] code);
        frame_t f;
        f.rsvd = 2'b00;
        f.pd   = PD_NORMAL;
        f.code = code;
        return f;
    endfunction

endpackage

// File: rtl/dac_scan_tick.sv
// Clock divider: one-cycle registered tick every CLK_DIV clk cycles.
module dac_scan_tick
    import dac_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                tick_q;

    always_comb begin
        cnt_d = cnt_q + DIV_BITS'(1);
        if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
        end
    end

    // tick_q is high exactly while cnt_q sits at its last value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= (DIV_LAST == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == DIV_LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/dac_scan_main.sv
// Serial DAC scan generator: frames a sawtooth (or, with DAC_SCAN_TRIANGLE_EN,
// a triangle) code sequence onto din/sync/clk_out and raises the supply enables.
module dac_scan_main
    import dac_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned STEP    = 1,
    parameter int unsigned GAP     = 2
) (
    input  logic clk,
    input  logic rst,
    output logic din,
    output logic sync,
    output logic clk_out,
    output logic vdd1,
    output logic vdd2
);

    localparam logic [DIV_BITS-1:0] GAP_LAST = DIV_BITS'(GAP - 1);
    localparam logic [IDX_BITS-1:0] IDX_MSB  = IDX_BITS'(FRAME_BITS - 1);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("dac_scan_main: CLK_DIV out of range 1..255");
    end
    if (GAP < 1 || GAP > 255) begin : g_bad_gap
        $error("dac_scan_main: GAP out of range 1..255");
    end
    if (STEP > 4095) begin : g_bad_step
        $error("dac_scan_main: STEP must fit in 12 bits");
    end

    logic tick;

    dac_scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    state_e               state_q;
    logic                 clk_out_q;
    logic                 sync_q;
    logic                 din_q;
    logic                 vdd_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [DIV_BITS-1:0]  gap_q;
    logic [CODE_BITS-1:0] code_q, code_d;
    frame_t               frame_q;
    frame_t               frame_c;
    logic                 frame_end_c;

    assign frame_c     = make_frame(code_q);
    assign frame_end_c = tick && (state_q == SHIFT) && !clk_out_q && (idx_q == '0);

`ifdef DAC_SCAN_TRIANGLE_EN
    logic                dir_q, dir_d;
    logic [SUM_BITS-1:0] up_sum, dn_diff;

    // Bounce between 0 and CODE_MAX, saturating at the bound on the turn-around frame
    always_comb begin
        up_sum  = {1'b0, code_q} + SUM_BITS'(STEP);
        dn_diff = {1'b0, code_q} - SUM_BITS'(STEP);
        code_d  = code_q;
        dir_d   = dir_q;
        if (dir_q == DIR_UP) begin
            if (up_sum[CODE_BITS]) begin
                code_d = CODE_MAX;
                dir_d  = DIR_DOWN;
            end else begin
                code_d = up_sum[CODE_BITS-1:0];
            end
        end else begin
            if (dn_diff[CODE_BITS]) begin
                code_d = '0;
                dir_d  = DIR_UP;
            end else begin
                code_d = dn_diff[CODE_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_UP;
        end else if (frame_end_c) begin
            dir_q <= dir_d;
        end
    end
`else
    always_comb begin
        code_d = code_q + CODE_BITS'(STEP);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
        end else if (frame_end_c) begin
            code_q <= code_d;
        end
    end

    // Frame FSM; every output is a register that only moves on a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_out_q <= 1'b1;
            sync_q    <= 1'b1;
            din_q     <= 1'b0;
            vdd_q     <= 1'b0;
            idx_q     <= '0;
            gap_q     <= '0;
            frame_q   <= '0;
        end else begin
            vdd_q <= 1'b1;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (gap_q == GAP_LAST) begin
                            gap_q   <= '0;
                            state_q <= START;
                        end else begin
                            gap_q <= gap_q + DIV_BITS'(1);
                        end
                    end
                    START: begin
                        frame_q <= frame_c;
                        sync_q  <= 1'b0;
                        din_q   <= frame_c[FRAME_BITS-1];
                        idx_q   <= IDX_MSB;
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_out_q) begin
                            clk_out_q <= 1'b0;
                        end else if (idx_q != '0) begin
                            clk_out_q <= 1'b1;
                            idx_q     <= idx_q - IDX_BITS'(1);
                            din_q     <= frame_q[idx_q - IDX_BITS'(1)];
                        end else begin
                            clk_out_q <= 1'b1;
                            sync_q    <= 1'b1;
                            din_q     <= 1'b0;
                            gap_q     <= '0;
                            state_q   <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign din     = din_q;
    assign sync    = sync_q;
    assign clk_out = clk_out_q;
    assign vdd1    = vdd_q;
    assign vdd2    = vdd_q;

endmodule

// File: tb/tb_dac_scan_main.sv
// Scoreboard bench for dac_scan_main: expected frame words are queued at reset
// release and compared against words reassembled from clk_out falling edges.
module tb_dac_scan_main;

`ifdef DAC_SCAN_TRIANGLE_EN
    localparam int STEP0 = 2048;
`else
    localparam int STEP0 = 1;
`endif
    localparam int STEP1 = 4095;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;

    logic din0, sync0, clk_out0, vdd1_0, vdd2_0;
    logic din1, sync1, clk_out1, vdd1_1, vdd2_1;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    logic pco0 = 1'b1, psy0 = 1'b1;
    logic pco1 = 1'b1, psy1 = 1'b1;
    logic [15:0] w0 = '0, w1 = '0;
    int nb0 = 0, nb1 = 0;
    int frames0 = 0, frames1 = 0;
    int cnt1 = 0, hi1 = 0, per1 = 0, high1 = 0;

    always #50 clk = ~clk;

    dac_scan_main #(.CLK_DIV(2), .STEP(STEP0), .GAP(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din0),
        .sync    (sync0),
        .clk_out (clk_out0),
        .vdd1    (vdd1_0),
        .vdd2    (vdd2_0)
    );

    dac_scan_main #(.CLK_DIV(1), .STEP(STEP1), .GAP(1)) dut_fast (
        .clk     (clk),
        .rst     (rst2),
        .din     (din1),
        .sync    (sync1),
        .clk_out (clk_out1),
        .vdd1    (vdd1_1),
        .vdd2    (vdd2_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected code sequence: {dir, code} -> next {dir, code}
    function automatic logic [12:0] model_next(input logic [12:0] s, input int step);
        int c;
        c = int'(s[11:0]);
`ifdef DAC_SCAN_TRIANGLE_EN
        if (s[12]) begin
            if (c + step > 4095) return {1'b0, 12'hFFF};
            return {1'b1, 12'(c + step)};
        end
        if (c - step < 0) return {1'b1, 12'h000};
        return {1'b0, 12'(c - step)};
`else
        return {1'b1, 12'(c + step)};
`endif
    endfunction

    task automatic push_frames0(input int n);
        logic [12:0] s;
        s = {1'b1, 12'd0};
        for (int i = 0; i < n; i++) begin
            q0.push_back({4'b0000, s[11:0]});
            s = model_next(s, STEP0);
        end
    endtask

    task automatic push_frames1(input int n);
        logic [12:0] s;
        s = {1'b1, 12'd0};
        for (int i = 0; i < n; i++) begin
            q1.push_back({4'b0000, s[11:0]});
            s = model_next(s, STEP1);
        end
    endtask

    task automatic wait_first_frame();
        int cyc;
        cyc = 0;
        #1;
        check("vdd1_held_low", vdd1_0, 0);
        while (sync0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("vdd1_up", vdd1_0, 1);
                check("vdd2_up", vdd2_0, 1);
            end
        end
        check("first_sync_fall", cyc, 6);
    endtask

    // Frame monitors, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (rst) begin
            pco0 = 1'b1; psy0 = 1'b1; nb0 = 0; w0 = '0;
        end else begin
            if (pco0 && !clk_out0 && !sync0) begin
                w0 = {w0[14:0], din0};
                nb0++;
            end
            if (!psy0 && sync0) begin
                check("bits0", nb0, 16);
                check("sb_has0", q0.size() > 0, 1);
                if (q0.size() > 0) check("word0", w0, q0.pop_front());
                frames0++;
                nb0 = 0;
                w0 = '0;
            end
            pco0 = clk_out0;
            psy0 = sync0;
        end

        if (rst2) begin
            pco1 = 1'b1; psy1 = 1'b1; nb1 = 0; w1 = '0; cnt1 = 0; hi1 = 0;
        end else begin
            cnt1++;
            if (sync1) hi1++;
            if (psy1 && !sync1) begin
                if (frames1 > 0) begin
                    per1  = cnt1;
                    high1 = hi1;
                end
                cnt1 = 0;
                hi1  = 0;
            end
            if (pco1 && !clk_out1 && !sync1) begin
                w1 = {w1[14:0], din1};
                nb1++;
            end
            if (!psy1 && sync1) begin
                check("bits1", nb1, 16);
                check("sb_has1", q1.size() > 0, 1);
                if (q1.size() > 0) check("word1", w1, q1.pop_front());
                frames1++;
                nb1 = 0;
                w1 = '0;
            end
            pco1 = clk_out1;
            psy1 = sync1;
        end
    end

    initial begin
        #5;
        rst  = 1'b1;
        rst2 = 1'b1;
        #20;
        check("rst_sync", sync0, 1);
        check("rst_clk_out", clk_out0, 1);
        check("rst_din", din0, 0);
        check("rst_vdd1", vdd1_0, 0);
        check("rst_vdd2", vdd2_0, 0);
        check("rst_sync_fast", sync1, 1);
        check("rst_clk_out_fast", clk_out1, 1);

        repeat (2) @(negedge clk);
        push_frames0(6);
        push_frames1(5);
        rst  = 1'b0;
        rst2 = 1'b0;

        fork
            begin
                wait_first_frame();
                for (int i = 0; i < 3000 && frames0 < 6; i++) @(negedge clk);
                check("frames0", frames0, 6);
                check("sb_drain0_a", q0.size(), 0);

                for (int i = 0; i < 400 && nb0 != 9; i++) @(posedge clk);
                check("abort_point", nb0, 9);
                #35;
                check("mid_frame_sync", sync0, 0);
                rst = 1'b1;
                #10;
                check("abort_sync", sync0, 1);
                check("abort_clk_out", clk_out0, 1);
                check("abort_din", din0, 0);
                check("abort_vdd1", vdd1_0, 0);
                check("abort_vdd2", vdd2_0, 0);
                q0.delete();
                push_frames0(2);
                #20;
                rst = 1'b0;
                wait_first_frame();
                for (int i = 0; i < 1000 && frames0 < 8; i++) @(negedge clk);
                check("frames0_post", frames0, 8);
                check("sb_drain0_b", q0.size(), 0);
            end
            begin
                for (int i = 0; i < 1000 && frames1 < 5; i++) @(negedge clk);
                check("frames1", frames1, 5);
                check("period1", per1, 34);
                check("sync_high1", high1, 2);
                check("sb_drain1", q1.size(), 0);
                rst2 = 1'b1;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
